bcd_seg_scan: RTL
=================

# bcd_seg_scan

Time-multiplexed two-digit 7-segment display driver. It sits directly downstream of the binary-to-BCD converter and consumes its tens and ones BCD digits. Digits are double-buffered so a new value is never shown mid-frame. Each digit slot starts with a dark gap to suppress ghosting. Outputs drive a common-anode display: segments and digit enables are both active-low.

## Interface
- DIV, 50000: clock cycles per digit slot; DIV >= 2
- BLANK, 500: dark cycles at the start of each slot; 0 <= BLANK < DIV
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_D1  in  4  tens BCD digit from the converter
- i_D0  in  4  ones BCD digit from the converter
- i_load  in  1  capture i_D1/i_D0 into the shadow register this cycle
- i_lz_blank  in  1  leading-zero blank: suppress the tens digit when it is 0; sampled live
- o_seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- o_an  out  2  digit enables, active-low; [1]=tens, [0]=ones
- o_frame  out  1  one-cycle pulse at the start of each frame
- o_pending  out  1  shadow holds a value not yet displayed

## Operation
- Registers:
  - slot counter cnt, 0..DIV-1, width $clog2(DIV)
  - slot flag: ONES or TENS
  - active digits act1/act0
  - shadow digits sh1/sh0
  - pending flag
- State machine: two states, ONES and TENS.
  - cnt increments every cycle.
  - When cnt==DIV-1: cnt<=0 and the state toggles.
  - Sequence: ONES -> TENS -> ONES. A frame is ONES followed by TENS, 2*DIV cycles.
- Load: on i_load, sh1<=i_D1, sh0<=i_D0, pending<=1. Any cycle is allowed. Repeated loads overwrite; the last value wins.
- Frame boundary is the edge where TENS -> ONES. At that edge, if pending: act<=sh and pending<=0.
- Load and boundary on the same edge: the old shadow moves to act, the new digits go to shadow, and pending stays 1.
- Output decode:
  - Outputs are registered.
  - Each edge loads them from the post-update cnt, state and act values, so outputs always match the current counter.
- Dark gap and digit selection:
  - cnt < BLANK: o_an=2'b11, o_seg=7'h7F.
  - Otherwise in ONES: o_an=2'b10, o_seg=dec(act0).
  - Otherwise in TENS: o_an=2'b01, o_seg=dec(act1).
  - Leading-zero blank: in TENS with i_lz_blank=1 and act1==0, force o_an=2'b11 and o_seg=7'h7F for the whole slot.
- dec(), active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - 10..15: dash, 3F
- o_frame: 1 in exactly the cycle where state==ONES and cnt==0, i.e. the register is set on the boundary edge. 0 otherwise.
- o_pending = the pending register.

## Timing
- Reset values, applied on the first edge with i_rst=1:
  - cnt=0, state=ONES
  - act=0, sh=0, pending=0
  - o_seg=7'h7F, o_an=2'b11, o_frame=0, o_pending=0
- Reset during a frame: all of the above apply on the next edge and any pending value is discarded. The first cycle after reset release has cnt=0 in ONES; no o_frame pulse is generated for it.
- Load latency: o_pending rises the edge after i_load. The new digits appear from the boundary edge onward, at most 2*DIV cycles later, and are lit from cnt==BLANK of that ONES slot.
- o_pending falls on the same edge that o_frame rises.
- Per slot: exactly BLANK dark cycles, then DIV-BLANK lit cycles.
- No two o_an bits are ever low together, including across slot transitions.

## Test plan
All scenarios use DIV=8, BLANK=2.
- Reset: hold i_rst 3 cycles -> o_seg=7F, o_an=11, o_frame=0, o_pending=0. After release with i_lz_blank=0: ONES cnt 2..7 gives o_an=10, o_seg=40; TENS cnt 2..7 gives o_an=01, o_seg=40.
- Load 59: i_load with D1=5, D0=9 at ONES cnt=3 -> o_pending=1 until the boundary 13 cycles later. At the boundary: o_frame=1, o_pending=0. Then ONES lit cycles o_seg=10/an=10, TENS lit cycles o_seg=12/an=01.
- Gap and period: free-run 4 frames -> each slot has 2 cycles at an=11 then 6 lit cycles; o_frame pulses every 16 cycles, width 1.
- Leading zero: load 07 with i_lz_blank=1 -> TENS slot entirely an=11/seg=7F, ONES lit o_seg=78. Drop i_lz_blank to 0 -> TENS lit o_seg=40 immediately.
- Invalid and collision: load D1=3, D0=12 -> ONES o_seg=3F. Assert i_load with 42 on the boundary edge -> 3/12 displays, o_pending stays 1, and 42 displays one frame later.
- Reset mid-operation: pending load active, i_rst at TENS cnt=5 -> next cycle shows reset values, and the pending value is never displayed.

Source files
------------

// File: rtl/bcd_seg_scan_if.sv
// Digit inputs and display outputs of the two-digit scan driver.
// The master side feeds BCD digits; the slave side is the driver itself.
interface bcd_seg_scan_if;
   logic [3:0] d1;
   logic [3:0] d0;
   logic       load;
   logic       lz_blank;
   logic [6:0] seg;
   logic [1:0] an;
   logic       frame;
   logic       pending;

   modport master (
      output d1, d0, load, lz_blank,
      input  seg, an, frame, pending
   );

   modport slave (
      input  d1, d0, load, lz_blank,
      output seg, an, frame, pending
   );
endinterface

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed two-digit common-anode 7-segment driver with a
// double-buffered digit pair, per-slot dark gap and leading-zero blanking.
module bcd_seg_scan #(
   parameter int unsigned DIV   = 50000,
   parameter int unsigned BLANK = 500
) (
   input  logic           i_clk,
   input  logic           i_rst,
   bcd_seg_scan_if.slave  bus
);

   localparam int unsigned CW = $clog2(DIV);
   localparam logic [CW-1:0] CntLast = CW'(DIV - 1);

   typedef enum logic {StOnes, StTens} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    act1_q, act1_d, act0_q, act0_d;
   logic [3:0]    sh1_q, sh1_d, sh0_q, sh0_d;
   logic          pending_q, pending_d;
   logic [6:0]    seg_q, seg_d;
   logic [1:0]    an_q, an_d;
   logic          frame_q, frame_d;
   logic          last, boundary;

   // Active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
   function automatic logic [6:0] dec(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   always_comb begin
      last      = (cnt_q == CntLast);
      boundary  = last && (state_q == StTens);
      cnt_d     = last ? '0 : cnt_q + CW'(1);
      state_d   = state_q;
      if (last) state_d = (state_q == StOnes) ? StTens : StOnes;

      act1_d    = act1_q;
      act0_d    = act0_q;
      sh1_d     = sh1_q;
      sh0_d     = sh0_q;
      pending_d = pending_q;
      // Promotion uses the old shadow, so a colliding load stays pending.
      if (boundary && pending_q) begin
         act1_d    = sh1_q;
         act0_d    = sh0_q;
         pending_d = 1'b0;
      end
      if (bus.load) begin
         sh1_d     = bus.d1;
         sh0_d     = bus.d0;
         pending_d = 1'b1;
      end

      // Outputs follow the post-update counter so they never lag a slot edge.
      seg_d   = 7'h7F;
      an_d    = 2'b11;
      frame_d = boundary;
      if (32'(cnt_d) >= BLANK) begin
         if (state_d == StOnes) begin
            an_d  = 2'b10;
            seg_d = dec(act0_d);
         end else if (!(bus.lz_blank && (act1_d == 4'd0))) begin
            an_d  = 2'b01;
            seg_d = dec(act1_d);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= StOnes;
         cnt_q     <= '0;
         act1_q    <= '0;
         act0_q    <= '0;
         sh1_q     <= '0;
         sh0_q     <= '0;
         pending_q <= 1'b0;
         seg_q     <= 7'h7F;
         an_q      <= 2'b11;
         frame_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         act1_q    <= act1_d;
         act0_q    <= act0_d;
         sh1_q     <= sh1_d;
         sh0_q     <= sh0_d;
         pending_q <= pending_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
         frame_q   <= frame_d;
      end
   end

   assign bus.seg     = seg_q;
   assign bus.an      = an_q;
   assign bus.frame   = frame_q;
   assign bus.pending = pending_q;

endmodule
